// File: rtl/rr_arbiter_pkg.sv
// Shared definitions for round-robin arbiters: FSM state type and
// the index-width helper used to size grant indices and pointers.
package rr_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } rr_state_e;

  // A single requester still needs a 1-bit index, hence the floor of 1.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Circular first-set-bit search starting at ptr_i, wrapping NUM_REQ-1 -> 0.
// Purely combinational; ptr_i is assumed to be in 0..NUM_REQ-1.
module rr_priority_select
  import rr_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               found_o
);

  int               w_pos;
  logic [IDX_W-1:0] w_cand;

  // Walk offsets from the farthest down to zero so the nearest hit wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    w_pos   = 0;
    w_cand  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_pos = int'(ptr_i) + k;
      if (w_pos >= NUM_REQ) w_pos = w_pos - NUM_REQ;
      w_cand = IDX_W'(w_pos);
      if (req_i[w_cand]) begin
        idx_o   = w_cand;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered binary grant index and a two-state FSM.
// Handshake: a grant transfers in any cycle where gnt_valid_o & gnt_ready_i;
// while gnt_valid_o is high and ready is low the grant is held unchanged.
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               arst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               gnt_valid_o,
  input  logic               gnt_ready_i,
  output rr_state_e          dbg_state_o,
  output logic [IDX_W-1:0]   dbg_ptr_o
);

  rr_state_e        r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_gnt_idx;
  logic             r_gnt_valid;

  logic             w_handshake;
  logic [IDX_W-1:0] w_ptr_inc;
  logic [IDX_W-1:0] w_sel_ptr;
  logic [IDX_W-1:0] w_sel_idx;
  logic             w_found;

  assign w_handshake = (r_state == GRANT) && gnt_ready_i;
  assign w_ptr_inc   = (r_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : IDX_W'(r_gnt_idx + 1'b1);
  // On a handshake the next pick already searches from the advanced pointer.
  assign w_sel_ptr   = w_handshake ? w_ptr_inc : r_ptr;

  rr_priority_select #(
    .NUM_REQ (NUM_REQ)
  ) u_select (
    .req_i   (req_i),
    .ptr_i   (w_sel_ptr),
    .idx_o   (w_sel_idx),
    .found_o (w_found)
  );

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_gnt_idx   <= '0;
      r_gnt_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_gnt_idx   <= w_sel_idx;
            r_gnt_valid <= 1'b1;
            r_state     <= GRANT;
          end
        end
        GRANT: begin
          if (gnt_ready_i) begin
            r_ptr <= w_ptr_inc;
            if (w_found) begin
              r_gnt_idx <= w_sel_idx;
            end else begin
              r_gnt_valid <= 1'b0;
              r_state     <= IDLE;
            end
          end
        end
      endcase
    end
  end

  assign gnt_idx_o   = r_gnt_idx;
  assign gnt_valid_o = r_gnt_valid;
  assign dbg_state_o = r_state;
  assign dbg_ptr_o   = r_ptr;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter at NUM_REQ=4 and NUM_REQ=5; expected grants
// are queued by the stimulus and popped by per-instance handshake monitors.
module tb_rr_arbiter;
  import rr_arbiter_pkg::*;

  logic       clk;
  logic       rst_n;

  logic [3:0] req4;
  logic [1:0] idx4;
  logic       valid4;
  logic       ready4;
  rr_state_e  state4;
  logic [1:0] ptr4;

  logic [4:0] req5;
  logic [2:0] idx5;
  logic       valid5;
  logic       ready5;
  rr_state_e  state5;
  logic [2:0] ptr5;

  logic [2:0] exp4_q[$];
  logic [2:0] exp5_q[$];

  int n_cmp = 0;
  int n_err = 0;

  rr_arbiter #(.NUM_REQ(4)) dut4 (
    .clk_i       (clk),
    .arst_ni     (rst_n),
    .req_i       (req4),
    .gnt_idx_o   (idx4),
    .gnt_valid_o (valid4),
    .gnt_ready_i (ready4),
    .dbg_state_o (state4),
    .dbg_ptr_o   (ptr4)
  );

  rr_arbiter #(.NUM_REQ(5)) dut5 (
    .clk_i       (clk),
    .arst_ni     (rst_n),
    .req_i       (req5),
    .gnt_idx_o   (idx5),
    .gnt_valid_o (valid5),
    .gnt_ready_i (ready5),
    .dbg_state_o (state5),
    .dbg_ptr_o   (ptr5)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish within 20000 time units");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: sampled on the falling edge, mid-cycle.
  always @(negedge clk) begin
    if (rst_n && valid4 && ready4) begin
      if (exp4_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL grant4_unexpected: got idx %0d, expected no handshake", idx4);
      end else begin
        check("grant4", 32'(idx4), 32'(exp4_q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && valid5) begin
      n_cmp++;
      if (idx5 > 3'd4) begin
        n_err++;
        $display("FAIL idx5_range: got %0d, expected <= 4", idx5);
      end
    end
    if (rst_n && valid5 && ready5) begin
      if (exp5_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL grant5_unexpected: got idx %0d, expected no handshake", idx5);
      end else begin
        check("grant5", 32'(idx5), 32'(exp5_q.pop_front()));
      end
    end
  end

  initial begin
    rst_n  = 1'b0;
    req4   = '0;
    ready4 = 1'b0;
    req5   = '0;
    ready5 = 1'b0;
    #3;
    check("rst_valid", 32'(valid4), 0);
    check("rst_idx",   32'(idx4),   0);
    check("rst_ptr",   32'(ptr4),   0);
    check("rst_state", 32'(state4), 32'(IDLE));
    #9;
    rst_n = 1'b1;
    cyc();

    // Rotation with all requesters active and the consumer always ready
    req4 = 4'b1111;
    ready4 = 1'b1;
    exp4_q.push_back(3'd0); exp4_q.push_back(3'd1); exp4_q.push_back(3'd2);
    exp4_q.push_back(3'd3); exp4_q.push_back(3'd0); exp4_q.push_back(3'd1);
    for (int i = 0; i < 6; i++) begin
      cyc();
      check("rot_valid", 32'(valid4), 1);
    end
    req4 = 4'b0000;
    cyc();
    check("rot_end_valid", 32'(valid4), 0);
    check("rot_end_ptr",   32'(ptr4),   2);
    ready4 = 1'b0;

    // Backpressure: grant must hold even after its request drops
    req4 = 4'b0100;
    exp4_q.push_back(3'd2);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("bp_valid", 32'(valid4), 1);
      check("bp_idx",   32'(idx4),   2);
      if (i == 0) req4 = 4'b0000;
    end
    ready4 = 1'b1;
    cyc();
    check("bp_done_valid", 32'(valid4), 0);
    check("bp_done_ptr",   32'(ptr4),   3);

    // Wrap from ptr=3 to 0, then skip 1 to reach 2
    req4 = 4'b0101;
    exp4_q.push_back(3'd0);
    exp4_q.push_back(3'd2);
    cyc();
    check("wrap_idx0", 32'(idx4), 0);
    cyc();
    check("wrap_idx2", 32'(idx4), 2);
    req4 = 4'b0000;
    cyc();
    check("wrap_end_valid", 32'(valid4), 0);
    check("wrap_end_ptr",   32'(ptr4),   3);

    // Idle gap: ready ignored, pointer frozen
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("idle_valid", 32'(valid4), 0);
      check("idle_ptr",   32'(ptr4),   3);
    end
    req4 = 4'b1000;
    exp4_q.push_back(3'd3);
    cyc();
    check("idle_gnt_valid", 32'(valid4), 1);
    check("idle_gnt_idx",   32'(idx4),   3);
    req4 = 4'b0000;
    cyc();
    check("idle_end_valid", 32'(valid4), 0);
    check("idle_end_ptr",   32'(ptr4),   0);

    // Asynchronous reset in the middle of a held grant of index 2
    ready4 = 1'b0;
    req4 = 4'b0100;
    cyc();
    check("pre_rst_valid", 32'(valid4), 1);
    check("pre_rst_idx",   32'(idx4),   2);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(valid4), 0);
    check("mid_rst_idx",   32'(idx4),   0);
    check("mid_rst_ptr",   32'(ptr4),   0);
    req4 = 4'b1111;
    #1;
    rst_n = 1'b1;
    ready4 = 1'b1;
    exp4_q.push_back(3'd0);
    cyc();
    check("post_rst_valid", 32'(valid4), 1);
    check("post_rst_idx",   32'(idx4),   0);
    req4 = 4'b0000;
    cyc();
    ready4 = 1'b0;

    // Non-power-of-two instance
    req5 = 5'b10001;
    ready5 = 1'b1;
    exp5_q.push_back(3'd0); exp5_q.push_back(3'd4);
    exp5_q.push_back(3'd0); exp5_q.push_back(3'd4);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("np2_valid", 32'(valid5), 1);
    end
    req5 = 5'b00000;
    cyc();
    check("np2_end_valid", 32'(valid5), 0);
    check("np2_end_state", 32'(state5), 32'(IDLE));
    check("np2_end_ptr",   32'(ptr5),   0);
    ready5 = 1'b0;

    cyc();
    check("q4_drained", 32'(exp4_q.size()), 0);
    check("q5_drained", 32'(exp5_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters; legal range 2..256, non-power-of-two legal.
REQ-002 Derived constant IDX_W SHALL equal max(1, ceil(log2(NUM_REQ))); it is not overridable.
REQ-003 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 arst_ni  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req_i  input  NUM_REQ  SHALL be the request vector; bit i high = requester i wants service; level-sensitive.
REQ-006 gnt_idx_o  output  IDX_W  SHALL carry the binary index of the granted requester; it is intended to drive a downstream binary-to-one-hot decoder.
REQ-007 gnt_valid_o  output  1  SHALL indicate gnt_idx_o holds a valid grant.
REQ-008 gnt_ready_i  input  1  SHALL indicate the consumer accepts the grant; handshake = gnt_valid_o & gnt_ready_i in one cycle.

Function
REQ-009 Block SHALL implement a two-state FSM: IDLE (gnt_valid_o=0) and GRANT (gnt_valid_o=1).
REQ-010 Block SHALL hold a priority pointer ptr (IDX_W bits, range 0..NUM_REQ-1).
REQ-011 Selection SHALL pick the first set bit of req_i searching circularly from ptr upward, wrapping from NUM_REQ-1 to 0.
REQ-012 IDLE: if req_i != 0, selected index SHALL be registered into gnt_idx_o and FSM SHALL enter GRANT; gnt_valid_o rises the cycle after the request is sampled (1-cycle latency).
REQ-013 IDLE with req_i == 0: no state change; gnt_idx_o SHALL keep its previous value.
REQ-014 GRANT without handshake: gnt_idx_o and gnt_valid_o SHALL stay stable, regardless of req_i changes, including deassertion of the granted request.
REQ-015 GRANT with handshake: ptr SHALL load gnt_idx_o+1, wrapping NUM_REQ-1 -> 0.
REQ-016 Same handshake cycle: selection SHALL use the updated pointer value (gnt_idx_o+1 wrapped) against current req_i; if any bit set, new index SHALL be registered and FSM SHALL stay in GRANT (back-to-back, gnt_valid_o stays 1); otherwise FSM SHALL go to IDLE.
REQ-017 gnt_idx_o SHALL never exceed NUM_REQ-1, including non-power-of-two NUM_REQ.
REQ-018 ptr SHALL change only on a handshake; ptr unaffected in IDLE.
REQ-019 With continuous all-ones req_i and gnt_ready_i=1, grants SHALL cycle 0,1,...,NUM_REQ-1,0 one per cycle, giving each requester one grant per NUM_REQ handshakes (starvation-free).
REQ-020 gnt_ready_i while IDLE SHALL be ignored.

Reset
REQ-021 arst_ni low SHALL immediately force FSM=IDLE, ptr=0, gnt_idx_o=0, gnt_valid_o=0, independent of clk_i.
REQ-022 Reset asserted mid-GRANT SHALL drop the pending grant without handshake; after release, arbitration restarts from ptr=0.
REQ-023 First grant decision SHALL occur on the first rising clk_i edge after arst_ni deasserts.

Structure
REQ-024 FSM state enumeration (IDLE, GRANT) SHALL live in the shared common package as a typedef.
REQ-025 Circular search SHALL be a sub-module rr_priority_select (inputs req vector, ptr; outputs index, found), purely combinational, reusable by other arbiters.
REQ-026 All registers SHALL sit in rr_arbiter; no combinational path from req_i to gnt_idx_o or gnt_valid_o; gnt_ready_i may combinationally affect only next-state logic.

Verification (NUM_REQ=4 unless stated)
REQ-027 Reset: arst_ni low mid-GRANT with idx=2 -> same cycle gnt_valid_o=0, gnt_idx_o=0; after release req_i=4'b1111 -> first grant idx 0.
REQ-028 Rotation: req_i=4'b1111, gnt_ready_i=1 constantly -> gnt_idx_o sequence 0,1,2,3,0,1 with gnt_valid_o continuously 1.
REQ-029 Backpressure/stability: req_i=4'b0100, gnt_ready_i=0 for 5 cycles then req_i=0 -> gnt_idx_o=2, gnt_valid_o=1 held all 5 cycles; one cycle after gnt_ready_i=1 -> gnt_valid_o=0, ptr=3.
REQ-030 Wrap/skip: ptr=3 (after grant 2), req_i=4'b0101 -> grant 0; next handshake -> grant 2.
REQ-031 Non-power-of-two: NUM_REQ=5, req_i=5'b10001, always ready -> indices 0,4,0,4; gnt_idx_o never 5..7.
REQ-032 Idle gap: req_i=0 for 3 cycles, gnt_ready_i=1 -> gnt_valid_o=0, ptr unchanged; then req_i=4'b1000 -> gnt_idx_o=3 one cycle later.
